// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-lite initiator: a command/response front end that
// issues one read or write at a time, with a sticky watchdog for stalled slaves.
module axi4_lite_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TMO_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,

    output logic                  busy,
    output logic                  timeout,

    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    typedef enum logic [2:0] {
        IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP
    } state_t;

    localparam logic [TMO_WIDTH-1:0] TMO_LIMIT = TMO_WIDTH'(TIMEOUT_CYCLES);

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
    logic                  aw_done, aw_done_d, w_done, w_done_d;
    logic                  rsp_valid_d, rsp_write_d;
    logic [31:0]           rsp_rdata_d;
    logic [1:0]            rsp_resp_d;
    logic                  timeout_d;
    logic [TMO_WIDTH-1:0]  tmo_cnt, tmo_cnt_d;

    logic accept, aw_fire, w_fire, b_fire, ar_fire, r_fire, any_fire, waiting;

    function automatic logic [TMO_WIDTH-1:0] sat_inc(input logic [TMO_WIDTH-1:0] v);
        return (v >= TMO_LIMIT) ? TMO_LIMIT : v + TMO_WIDTH'(1);
    endfunction

    assign cmd_ready = resetn && (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign aw_fire   = m_axi_awvalid && m_axi_awready;
    assign w_fire    = m_axi_wvalid && m_axi_wready;
    assign b_fire    = m_axi_bvalid && m_axi_bready;
    assign ar_fire   = m_axi_arvalid && m_axi_arready;
    assign r_fire    = m_axi_rvalid && m_axi_rready;
    assign any_fire  = aw_fire || w_fire || b_fire || ar_fire || r_fire;
    assign waiting   = (state == WR) || (state == WR_RESP) ||
                       (state == RD_ADDR) || (state == RD_DATA);

    // Address and write payload share one register set for both channels.
    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_wdata  = wdata_q;
    assign m_axi_wstrb  = wstrb_q;

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = cmd_write ? WR : RD_ADDR;
            WR:      if ((aw_done || aw_fire) && (w_done || w_fire)) state_next = WR_RESP;
            WR_RESP: if (b_fire) state_next = RSP;
            RD_ADDR: if (ar_fire) state_next = RD_DATA;
            RD_DATA: if (r_fire) state_next = RSP;
            RSP:     if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = m_axi_awvalid;
        wvalid_d    = m_axi_wvalid;
        bready_d    = m_axi_bready;
        arvalid_d   = m_axi_arvalid;
        rready_d    = m_axi_rready;
        aw_done_d   = aw_done;
        w_done_d    = w_done;
        rsp_valid_d = rsp_valid;
        rsp_write_d = rsp_write;
        rsp_rdata_d = rsp_rdata;
        rsp_resp_d  = rsp_resp;
        timeout_d   = timeout;
        tmo_cnt_d   = tmo_cnt;
        case (state)
            IDLE: if (accept) begin
                addr_d    = cmd_addr;
                wdata_d   = cmd_wdata;
                wstrb_d   = cmd_wstrb;
                awvalid_d = cmd_write;
                wvalid_d  = cmd_write;
                arvalid_d = !cmd_write;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                timeout_d = 1'b0;
                tmo_cnt_d = '0;
            end
            WR: begin
                if (aw_fire) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_fire) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (state_next == WR_RESP) bready_d = 1'b1;
            end
            WR_RESP: if (b_fire) begin
                bready_d    = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_write_d = 1'b1;
                rsp_rdata_d = '0;
                rsp_resp_d  = m_axi_bresp;
            end
            RD_ADDR: if (ar_fire) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
            end
            RD_DATA: if (r_fire) begin
                rready_d    = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_write_d = 1'b0;
                rsp_rdata_d = m_axi_rdata;
                rsp_resp_d  = m_axi_rresp;
            end
            RSP: if (rsp_ready) rsp_valid_d = 1'b0;
            default: ;
        endcase
        // Watchdog only observes; the transaction itself is never abandoned.
        if (waiting) begin
            tmo_cnt_d = any_fire ? '0 : sat_inc(tmo_cnt);
            if (tmo_cnt_d == TMO_LIMIT) timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= '0;
            timeout       <= 1'b0;
            tmo_cnt       <= '0;
        end else begin
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            m_axi_awvalid <= awvalid_d;
            m_axi_wvalid  <= wvalid_d;
            m_axi_bready  <= bready_d;
            m_axi_arvalid <= arvalid_d;
            m_axi_rready  <= rready_d;
            aw_done       <= aw_done_d;
            w_done        <= w_done_d;
            rsp_valid     <= rsp_valid_d;
            rsp_write     <= rsp_write_d;
            rsp_rdata     <= rsp_rdata_d;
            rsp_resp      <= rsp_resp_d;
            timeout       <= timeout_d;
            tmo_cnt       <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: behavioural AXI4-lite slave with tunable stalls,
// a shadow-memory reference model, directed corner cases and random traffic.
module tb_axi4_lite_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        busy, timeout;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    axi4_lite_master #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy), .timeout(timeout),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave memory, reference-model shadow memory, and per-address response code.
    logic [31:0] smem [16];
    logic [31:0] mmem [16];

    function automatic logic [1:0] resp_for(input logic [31:0] a);
        return a[9:8];
    endfunction

    bit rand_dly = 0, ar_hold = 0;
    int aw_dly_cfg = 0, w_dly_cfg = 0, ar_dly_cfg = 0, b_dly_cfg = 0, r_dly_cfg = 0;

    function automatic int pick(input int cfg);
        return rand_dly ? int'($urandom_range(0, 3)) : cfg;
    endfunction

    initial begin : slave
        bit aw_seen, w_seen, ar_seen, aw_hs, w_hs, ar_hs, b_hs, r_hs;
        bit have_aw, have_w, b_pend, r_pend;
        int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        logic [31:0] s_awaddr, s_wdata, s_araddr;
        logic [3:0]  s_wstrb;
        {aw_seen, w_seen, ar_seen, aw_hs, w_hs, ar_hs, b_hs, r_hs} = '0;
        {have_aw, have_w, b_pend, r_pend} = '0;
        {aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt} = '0;
        {s_awaddr, s_wdata, s_araddr, s_wstrb} = '0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                {aw_seen, w_seen, ar_seen, aw_hs, w_hs, ar_hs, b_hs, r_hs} = '0;
                {have_aw, have_w, b_pend, r_pend} = '0;
                m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
                m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = 0;
            end else begin
                if (aw_hs) have_aw = 1;
                if (w_hs) have_w = 1;
                if (b_hs) m_axi_bvalid = 0;
                if (r_hs) m_axi_rvalid = 0;
                if (ar_hs) begin r_pend = 1; r_cnt = pick(r_dly_cfg); end
                if (have_aw && have_w) begin
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) smem[s_awaddr[5:2]][8*b +: 8] = s_wdata[8*b +: 8];
                    have_aw = 0; have_w = 0; b_pend = 1; b_cnt = pick(b_dly_cfg);
                end
                if (b_pend) begin
                    if (b_cnt == 0) begin
                        m_axi_bvalid = 1; m_axi_bresp = resp_for(s_awaddr); b_pend = 0;
                    end else b_cnt--;
                end
                if (r_pend) begin
                    if (r_cnt == 0) begin
                        m_axi_rvalid = 1; m_axi_rdata = smem[s_araddr[5:2]];
                        m_axi_rresp = resp_for(s_araddr); r_pend = 0;
                    end else r_cnt--;
                end
                if (!m_axi_awvalid) begin m_axi_awready = 0; aw_seen = 0; end
                else begin
                    if (!aw_seen) begin aw_seen = 1; aw_cnt = pick(aw_dly_cfg); end
                    if (aw_cnt == 0) m_axi_awready = 1; else begin m_axi_awready = 0; aw_cnt--; end
                end
                if (!m_axi_wvalid) begin m_axi_wready = 0; w_seen = 0; end
                else begin
                    if (!w_seen) begin w_seen = 1; w_cnt = pick(w_dly_cfg); end
                    if (w_cnt == 0) m_axi_wready = 1; else begin m_axi_wready = 0; w_cnt--; end
                end
                if (!m_axi_arvalid) begin m_axi_arready = 0; ar_seen = 0; end
                else begin
                    if (!ar_seen) begin ar_seen = 1; ar_cnt = pick(ar_dly_cfg); end
                    if (ar_hold) m_axi_arready = 0;
                    else if (ar_cnt == 0) m_axi_arready = 1;
                    else begin m_axi_arready = 0; ar_cnt--; end
                end
                aw_hs = m_axi_awvalid && m_axi_awready;
                w_hs  = m_axi_wvalid && m_axi_wready;
                ar_hs = m_axi_arvalid && m_axi_arready;
                b_hs  = m_axi_bvalid && m_axi_bready;
                r_hs  = m_axi_rvalid && m_axi_rready;
                if (aw_hs) s_awaddr = m_axi_awaddr;
                if (w_hs) begin s_wdata = m_axi_wdata; s_wstrb = m_axi_wstrb; end
                if (ar_hs) s_araddr = m_axi_araddr;
            end
        end
    end

    // Protocol watcher: a pending valid must persist with a stable payload.
    initial begin : monitor
        bit p_aw, p_w, p_ar, p_rsp;
        logic [31:0] p_awaddr, p_wdata, p_araddr;
        logic [3:0]  p_wstrb;
        logic [34:0] p_rspv;
        {p_aw, p_w, p_ar, p_rsp} = '0;
        {p_awaddr, p_wdata, p_araddr, p_wstrb, p_rspv} = '0;
        forever begin
            @(negedge clk);
            #1;
            if (p_aw) begin chk("aw_hold", m_axi_awvalid, 1); chk("aw_stable", m_axi_awaddr, p_awaddr); end
            if (p_w) begin chk("w_hold", m_axi_wvalid, 1); chk("w_stable", {m_axi_wstrb, m_axi_wdata}, {p_wstrb, p_wdata}); end
            if (p_ar) begin chk("ar_hold", m_axi_arvalid, 1); chk("ar_stable", m_axi_araddr, p_araddr); end
            if (p_rsp) begin chk("rsp_hold", rsp_valid, 1); chk("rsp_stable", {rsp_write, rsp_resp, rsp_rdata}, p_rspv); end
            if (resetn) chk("one_outstanding", m_axi_awvalid && m_axi_arvalid, 0);
            p_aw  = resetn && m_axi_awvalid && !m_axi_awready;
            p_w   = resetn && m_axi_wvalid && !m_axi_wready;
            p_ar  = resetn && m_axi_arvalid && !m_axi_arready;
            p_rsp = resetn && rsp_valid && !rsp_ready;
            p_awaddr = m_axi_awaddr; p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb;
            p_araddr = m_axi_araddr; p_rspv = {rsp_write, rsp_resp, rsp_rdata};
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic model_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [31:0] er, output logic [1:0] ep);
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) mmem[a[5:2]][8*b +: 8] = d[8*b +: 8];
            er = 32'h0;
        end else er = mmem[a[5:2]];
        ep = resp_for(a);
    endtask

    task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        chk("cmd_accept", cmd_ready, 1);
        tick();
        cmd_valid = 0;
    endtask

    task automatic expect_rsp(input bit wr, input logic [31:0] rd, input logic [1:0] rp, input int rdy_dly);
        int n = 0;
        while (!rsp_valid && n < 60) begin tick(); n++; end
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_write", rsp_write, wr);
        chk("rsp_rdata", rsp_rdata, rd);
        chk("rsp_resp", rsp_resp, rp);
        repeat (rdy_dly) tick();
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("rsp_drop", rsp_valid, 0);
    endtask

    initial begin : main
        logic [31:0] er, er2, a, d;
        logic [1:0]  ep, ep2;
        logic [3:0]  s;
        bit          wr;
        int          n;
        resetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
        for (int i = 0; i < 16; i++) begin
            smem[i] = 32'h1000_0000 + i * 32'h0101_0101;
            mmem[i] = smem[i];
        end
        smem[0] = 32'h1234_5678;
        mmem[0] = 32'h1234_5678;
        repeat (3) tick();
        chk("rst_awvalid", m_axi_awvalid, 0); chk("rst_wvalid", m_axi_wvalid, 0);
        chk("rst_arvalid", m_axi_arvalid, 0); chk("rst_bready", m_axi_bready, 0);
        chk("rst_rready", m_axi_rready, 0); chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0); chk("rst_timeout", timeout, 0);
        chk("rst_cmd_ready", cmd_ready, 0); chk("rst_awaddr", m_axi_awaddr, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        resetn = 1;
        #1 chk("rst_release_cmd_ready", cmd_ready, 1);
        tick();

        // Read with an always-ready slave: arvalid N+1, rready N+2, response N+3.
        model_cmd(0, 32'h0, 0, 0, er, ep);
        issue(0, 32'h0, 0, 0);
        chk("rd_arvalid", m_axi_arvalid, 1); chk("rd_araddr", m_axi_araddr, 0); chk("rd_busy", busy, 1);
        tick();
        chk("rd_rready", m_axi_rready, 1); chk("rd_arvalid_drop", m_axi_arvalid, 0);
        tick();
        chk("rd_rsp_n3", rsp_valid, 1);
        expect_rsp(0, er, ep, 0);

        // Write with an always-ready slave.
        model_cmd(1, 32'h0, 32'hA5A5_0001, 4'hF, er, ep);
        issue(1, 32'h0, 32'hA5A5_0001, 4'hF);
        chk("wr_awvalid", m_axi_awvalid, 1); chk("wr_wvalid", m_axi_wvalid, 1);
        chk("wr_awaddr", m_axi_awaddr, 0); chk("wr_wdata", m_axi_wdata, 32'hA5A5_0001);
        chk("wr_wstrb", m_axi_wstrb, 4'hF);
        tick();
        chk("wr_bready", m_axi_bready, 1); chk("wr_no_rsp_yet", rsp_valid, 0);
        tick();
        chk("wr_rsp_n3", rsp_valid, 1);
        expect_rsp(1, 32'h0, ep, 0);

        // AW accepted three cycles after W.
        aw_dly_cfg = 3;
        model_cmd(1, 32'h14, 32'h0BAD_BEEF, 4'hF, er, ep);
        issue(1, 32'h14, 32'h0BAD_BEEF, 4'hF);
        chk("skew_both_valid", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("skew_wvalid_drop", m_axi_wvalid, 0); chk("skew_awvalid_held", m_axi_awvalid, 1);
            chk("skew_awaddr", m_axi_awaddr, 32'h14); chk("skew_no_bready", m_axi_bready, 0);
        end
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick(); n++;
            chk("skew_bready_order", m_axi_bready && (m_axi_awvalid || m_axi_wvalid), 0);
        end
        expect_rsp(1, 32'h0, ep, 0);
        repeat (3) tick();
        chk("skew_single_rsp", rsp_valid, 0);
        aw_dly_cfg = 0;

        // Response back-pressure with the next command already waiting.
        model_cmd(0, 32'h14, 0, 0, er, ep);
        issue(0, 32'h14, 0, 0);
        n = 0;
        while (!rsp_valid && n < 40) begin tick(); n++; end
        chk("hold_rsp_valid", rsp_valid, 1);
        model_cmd(1, 32'h8, 32'hCAFE_F00D, 4'b0101, er2, ep2);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h8; cmd_wdata = 32'hCAFE_F00D; cmd_wstrb = 4'b0101;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", rsp_valid, 1); chk("hold_rdata", rsp_rdata, er);
            chk("hold_write", rsp_write, 0); chk("hold_cmd_ready", cmd_ready, 0);
            tick();
        end
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("post_rsp_cmd_ready", cmd_ready, 1); chk("post_rsp_valid", rsp_valid, 0);
        chk("post_rsp_busy", busy, 0);
        tick();
        cmd_valid = 0;
        chk("next_cmd_accepted", busy, 1); chk("next_cmd_ready_low", cmd_ready, 0);
        expect_rsp(1, 32'h0, ep2, 0);

        // Watchdog on a stalled AR channel.
        ar_hold = 1;
        model_cmd(0, 32'h8, 0, 0, er, ep);
        issue(0, 32'h8, 0, 0);
        for (int i = 0; i < 8; i++) begin
            chk("tmo_not_yet", timeout, 0);
            tick();
        end
        chk("tmo_set", timeout, 1); chk("tmo_arvalid_held", m_axi_arvalid, 1);
        repeat (3) tick();
        chk("tmo_sticky", timeout, 1); chk("tmo_arvalid_still", m_axi_arvalid, 1);
        ar_hold = 0;
        expect_rsp(0, er, ep, 0);
        chk("tmo_after_rsp", timeout, 1);
        model_cmd(0, 32'h0, 0, 0, er, ep);
        issue(0, 32'h0, 0, 0);
        chk("tmo_clear_on_accept", timeout, 0);
        expect_rsp(0, er, ep, 0);

        // Random traffic with random stalls kept below the watchdog limit.
        rand_dly = 1;
        for (int t = 0; t < 40; t++) begin
            wr = 1'($urandom_range(0, 1));
            a  = $urandom & 32'h0000_033C;
            d  = $urandom;
            s  = 4'($urandom_range(0, 15));
            model_cmd(wr, a, d, s, er, ep);
            issue(wr, a, d, s);
            expect_rsp(wr, er, ep, $urandom_range(0, 2));
        end
        chk("rand_no_timeout", timeout, 0);
        rand_dly = 0;

        // Reset while a SLVERR write response is still pending at the slave.
        b_dly_cfg = 5;
        issue(1, 32'h23C, 32'hDEAD_0000, 4'hF);
        n = 0;
        while (!m_axi_bready && n < 20) begin tick(); n++; end
        chk("rstmid_bready", m_axi_bready, 1); chk("rstmid_no_rsp", rsp_valid, 0);
        resetn = 0;
        tick();
        chk("rstmid_awvalid", m_axi_awvalid, 0); chk("rstmid_wvalid", m_axi_wvalid, 0);
        chk("rstmid_bready_drop", m_axi_bready, 0); chk("rstmid_arvalid", m_axi_arvalid, 0);
        chk("rstmid_rready", m_axi_rready, 0); chk("rstmid_busy", busy, 0);
        chk("rstmid_rsp_valid", rsp_valid, 0); chk("rstmid_cmd_ready", cmd_ready, 0);
        resetn = 1;
        b_dly_cfg = 0;
        #1 chk("rstmid_release_cmd_ready", cmd_ready, 1);
        repeat (8) tick();
        chk("rstmid_no_late_rsp", rsp_valid, 0); chk("rstmid_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : guard
        #200000;
        $display("FAIL global_timeout: got 0x0 expected 0x1");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/axi4_lite_master.md
Name: axi4_lite_master

Overview:
- AXI4-lite initiator that turns a simple command/response interface into single AXI4-lite read or write transactions.
- It is the driving end for memory-mapped slaves in the zynq subsystem, such as the GPIO slave, and lets fabric logic and testbenches poke registers without a PS.
- One transaction is outstanding at a time.
- A watchdog flags a slave that stalls.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr, m_axi_awaddr and m_axi_araddr.
- TIMEOUT_CYCLES, 1024, wait-state cycles without a handshake before the timeout flag sets; must be ≥1.
- TMO_WIDTH, $clog2(TIMEOUT_CYCLES+1), width of the watchdog counter.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE and only while resetn=1.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  response belongs to a write.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP as returned by the slave.
- busy  out  1  state is not IDLE.
- timeout  out  1  sticky watchdog flag.
- m_axi_awaddr  out  ADDR_WIDTH.
- m_axi_awvalid  out  1.
- m_axi_awready  in  1.
- m_axi_wdata  out  32.
- m_axi_wstrb  out  4.
- m_axi_wvalid  out  1.
- m_axi_wready  in  1.
- m_axi_bresp  in  2.
- m_axi_bvalid  in  1.
- m_axi_bready  out  1.
- m_axi_araddr  out  ADDR_WIDTH.
- m_axi_arvalid  out  1.
- m_axi_arready  in  1.
- m_axi_rdata  in  32.
- m_axi_rresp  in  2.
- m_axi_rvalid  in  1.
- m_axi_rready  out  1.

Behaviour:
- Reset (resetn=0 sampled at a clk edge):
  - Outputs go to 0: all m_axi valid/ready outputs, rsp_valid, rsp_*, busy, timeout, and all address/data registers.
  - State goes to IDLE.
  - cmd_ready=0 while resetn=0.
  - Reset mid-transaction drops all valids on the next edge with no completion response; the slave is reset on the same resetn.
- All m_axi outputs and rsp_* are registered.
- States: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE:
  - A command is accepted on cmd_valid&&cmd_ready.
  - Address, data, strobes and direction are latched; timeout clears; the watchdog counter clears.
  - Write goes to WR with awvalid=wvalid=1 on the next cycle.
  - Read goes to RD_ADDR with arvalid=1 on the next cycle.
- WR:
  - awvalid and wvalid are each held high until their own handshake, then dropped independently.
  - Two flags record aw_done and w_done.
  - Both handshakes may occur in the same cycle, or either may come first.
  - When both are done, go to WR_RESP with bready=1 on the next cycle.
  - AW/W payloads stay stable while valid is high; valid never drops before its handshake.
- WR_RESP:
  - On bvalid&&bready: capture bresp, set rsp_write=1 and rsp_rdata=0, drop bready, go to RSP.
- RD_ADDR:
  - On arvalid&&arready: drop arvalid, go to RD_DATA with rready=1 on the next cycle.
- RD_DATA:
  - On rvalid&&rready: capture rdata and rresp, set rsp_write=0, drop rready, go to RSP.
- RSP:
  - rsp_valid=1, with rsp_* held stable, until rsp_ready is seen.
  - Then go to IDLE; cmd_ready is high on the following cycle (no back-to-back accept in the rsp_ready cycle).
- Latency with an always-ready slave that answers B/R one cycle after the handshake:
  - Accept at edge N; AW/W (or AR) handshake at N+1; bready/rready high from N+2; B/R at N+3; rsp_valid from N+3.
- Watchdog:
  - Counts cycles in WR, WR_RESP, RD_ADDR and RD_DATA; resets to 0 on any AXI handshake and on state entry.
  - Saturates at TIMEOUT_CYCLES; timeout sets when the count reaches TIMEOUT_CYCLES.
  - timeout stays set until the next command accept or reset.
  - The transaction is never aborted: valids stay asserted, as AXI requires.
- Non-OKAY responses (SLVERR/DECERR) are passed through in rsp_resp; they are not errors inside this block.
- m_axi_awaddr and m_axi_araddr are driven unmodified from cmd_addr; no alignment check.

Test Plan:
- Write addr=0x0 data=0xA5A5_0001 wstrb=0xF to an always-ready slave:
  - awvalid&wvalid high at N+1 with awaddr=0, wdata=0xA5A5_0001.
  - rsp_valid at N+3 with rsp_write=1, rsp_resp=0, rsp_rdata=0.
- Read addr=0x0, slave rdata=0x1234_5678 rresp=0:
  - arvalid at N+1, rready at N+2.
  - rsp_rdata=0x1234_5678, rsp_write=0.
- Skewed write, wready 3 cycles before awready:
  - wvalid drops after its handshake; awvalid stays high with a stable awaddr.
  - bready is asserted only after both handshakes; exactly one rsp.
- rsp_ready held low 5 cycles:
  - rsp_valid and rsp_* stable for 5 cycles; cmd_ready=0 throughout.
  - The next command is accepted the cycle after rsp_ready.
- TIMEOUT_CYCLES=8, arready held 0:
  - timeout=1 after 8 RD_ADDR cycles; arvalid still 1.
  - Releasing arready completes the read normally; timeout clears on the next accept.
- resetn=0 during WR_RESP, bresp=SLVERR pending:
  - All valids/readies are 0 and busy=0 on the next edge; no rsp_valid.
  - cmd_ready=1 the first cycle resetn=1.
